// File: rtl/neuron_update_scheduler.sv
// Per-timestep LIF sweep controller: read, integrate, threshold, write back and emit spikes.
// Optional leak path enabled by defining NEURON_LEAK_EN (adds the leak_shift input).
module neuron_update_scheduler #(
    parameter int N_NEURONS = 16,
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              start,
    input  logic [DATA_W-1:0] v_threshold,
`ifdef NEURON_LEAK_EN
    input  logic [4:0]        leak_shift,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic [DATA_W-1:0] in_rd_data,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              in_clr,
    output logic              spike_valid,
    input  logic              spike_ready,
    output logic [ADDR_W-1:0] spike_id,
    output logic [ADDR_W:0]   spike_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_READ    = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_WRITE   = 3'd3;
    localparam logic [2:0] S_SPIKE   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(N_NEURONS - 1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              spiked_q, spiked_d;

    logic signed [DATA_W-1:0] sum_c;
    logic                     spiked_c;
    logic                     last_c;

    // Integrate: old potential (optionally leaked) plus accumulated input, wrapping at DATA_W.
    always_comb begin
`ifdef NEURON_LEAK_EN
        sum_c = $signed(mem_rd_data) - ($signed(mem_rd_data) >>> leak_shift)
              + $signed(in_rd_data);
`else
        sum_c = $signed(mem_rd_data) + $signed(in_rd_data);
`endif
        spiked_c = (sum_c >= $signed(v_threshold));
    end

    assign last_c = (index_q == LAST_INDEX);

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        count_d   = count_q;
        wr_data_d = wr_data_q;
        spiked_d  = spiked_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    index_d = '0;
                    count_d = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                spiked_d  = spiked_c;
                wr_data_d = spiked_c ? DATA_W'(sum_c - $signed(v_threshold)) : DATA_W'(sum_c);
                state_d   = S_WRITE;
            end
            S_WRITE: begin
                if (spiked_q) begin
                    state_d = S_SPIKE;
                end else if (last_c) begin
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_SPIKE: begin
                // Event stays presented until the packetiser takes it, so none is lost or repeated.
                if (spike_ready) begin
                    count_d = count_q + 1'b1;
                    if (last_c) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            index_q   <= '0;
            count_q   <= '0;
            wr_data_q <= '0;
            spiked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            count_q   <= count_d;
            wr_data_q <= wr_data_d;
            spiked_q  <= spiked_d;
        end
    end

    assign busy        = (state_q == S_READ) || (state_q == S_CAPTURE) ||
                         (state_q == S_WRITE) || (state_q == S_SPIKE);
    assign done        = (state_q == S_DONE);
    assign mem_addr    = index_q;
    assign mem_rd_en   = (state_q == S_READ);
    assign mem_wr_en   = (state_q == S_WRITE);
    assign in_clr      = (state_q == S_WRITE);
    assign mem_wr_data = wr_data_q;
    assign spike_valid = (state_q == S_SPIKE);
    assign spike_id    = (state_q == S_SPIKE) ? index_q : '0;
    assign spike_count = count_q;

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Directed bench for neuron_update_scheduler with a 4-neuron core, memory model and spike sink.
module tb_neuron_update_scheduler;

    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] v_threshold = 32'd100;
    logic          busy, done, mem_rd_en, mem_wr_en, in_clr, spike_valid;
    logic          spike_ready = 1'b0;
    logic [AW-1:0] mem_addr, spike_id;
    logic [AW:0]   spike_count;
    logic [DW-1:0] mem_rd_data = '0;
    logic [DW-1:0] in_rd_data = '0;
    logic [DW-1:0] mem_wr_data;
`ifdef NEURON_LEAK_EN
    logic [4:0]    leak_shift = 5'd31;
`endif

    int testsRun = 0;
    int testsFailed = 0;

    logic [DW-1:0] pot [N];
    logic [DW-1:0] inp [N];
    logic [DW-1:0] wrVal [N];
    int            wrCount, clrErr, exclErr, hsCount, stabErr, doneCount;
    int            readyWait = 0;
    int            waitCnt = 0;
    logic [AW-1:0] hsIds [$];
    logic          rdPending = 1'b0;
    logic [AW-1:0] rdAddr = '0;
    logic          prevValid = 1'b0;
    logic [AW-1:0] prevId = '0;
    int            cyc;

    neuron_update_scheduler #(.N_NEURONS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .start(start),
        .v_threshold(v_threshold),
`ifdef NEURON_LEAK_EN
        .leak_shift(leak_shift),
`endif
        .busy(busy),
        .done(done),
        .mem_addr(mem_addr),
        .mem_rd_en(mem_rd_en),
        .mem_rd_data(mem_rd_data),
        .in_rd_data(in_rd_data),
        .mem_wr_en(mem_wr_en),
        .mem_wr_data(mem_wr_data),
        .in_clr(in_clr),
        .spike_valid(spike_valid),
        .spike_ready(spike_ready),
        .spike_id(spike_id),
        .spike_count(spike_count)
    );

    always #5 CLK = ~CLK;

    // Memory model, write logger and spike sink, all sampled half a cycle after the active edge.
    always @(negedge CLK) begin
        if (RESET) begin
            rdPending   = 1'b0;
            spike_ready = 1'b0;
            waitCnt     = 0;
            prevValid   = 1'b0;
        end else begin
            mem_rd_data = rdPending ? pot[rdAddr[1:0]] : 32'hDEAD_BEEF;
            in_rd_data  = rdPending ? inp[rdAddr[1:0]] : 32'hDEAD_BEEF;
            rdPending   = mem_rd_en;
            rdAddr      = mem_addr;
            if (mem_wr_en) begin
                if (mem_addr < AW'(N)) wrVal[mem_addr[1:0]] = mem_wr_data;
                wrCount++;
                if (!in_clr) clrErr++;
            end
            if (mem_rd_en && mem_wr_en) exclErr++;
            if (done) doneCount++;
            if (spike_ready) begin
                hsCount++;
                hsIds.push_back(prevId);
                spike_ready = 1'b0;
                waitCnt     = 0;
                prevValid   = 1'b0;
            end else if (prevValid && !spike_valid) begin
                stabErr++;
            end
            if (spike_valid) begin
                if (prevValid && spike_id != prevId) stabErr++;
                prevValid = 1'b1;
                prevId    = spike_id;
                waitCnt++;
                if (waitCnt > readyWait) spike_ready = 1'b1;
            end else begin
                prevValid = 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] p0, p1, p2, p3,
                                 input logic [DW-1:0] i0, i1, i2, i3);
        pot[0] = p0; pot[1] = p1; pot[2] = p2; pot[3] = p3;
        inp[0] = i0; inp[1] = i1; inp[2] = i2; inp[3] = i3;
        for (int i = 0; i < N; i++) wrVal[i] = 32'hBAD0_BAD0;
        wrCount = 0; clrErr = 0; exclErr = 0; hsCount = 0; stabErr = 0; doneCount = 0;
        hsIds.delete();
    endtask

    // Accept a start, optionally pulse start again at cycle pulseAt, return cycles until done.
    task automatic runSweep(input int pulseAt, output int cycles);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 300) begin
            @(negedge CLK);
            cycles++;
            start = (cycles == pulseAt);
        end
        start = 1'b0;
        if (cycles >= 300) checkOutput("sweep timeout", 64'(cycles), 64'd0);
        @(negedge CLK);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " strobes"}, {busy, done, mem_rd_en, mem_wr_en, in_clr, spike_valid}, 6'b0);
        checkOutput({tag, " mem_addr"}, mem_addr, 0);
        checkOutput({tag, " mem_wr_data"}, mem_wr_data, 0);
        checkOutput({tag, " spike_id"}, spike_id, 0);
        checkOutput({tag, " spike_count"}, spike_count, 0);
    endtask

    function automatic logic [AW-1:0] hsId(input int k);
        return (hsIds.size() > k) ? hsIds[k] : 4'hF;
    endfunction

    initial begin
        repeat (3) @(negedge CLK);
        #1;
        checkAllZero("reset");
        RESET = 1'b0;

`ifdef NEURON_LEAK_EN
        leak_shift = 5'd1;
        applyStimulus(80, 0, 0, 0, 10, 0, 0, 0);
        runSweep(0, cyc);
        checkOutput("leak1 wr0", wrVal[0], 50);
        checkOutput("leak1 spikes", hsCount, 0);
        checkOutput("leak1 cycles", cyc, 13);
        leak_shift = 5'd0;
        applyStimulus(80, 0, 0, 0, 10, 0, 0, 0);
        runSweep(0, cyc);
        checkOutput("leak0 wr0", wrVal[0], 10);
        checkOutput("leak0 spikes", hsCount, 0);
`else
        // No spikes: plain accumulation and 3N+1 latency.
        applyStimulus(10, 20, 30, 40, 1, 2, 3, 4);
        runSweep(0, cyc);
        checkOutput("nospk wr0", wrVal[0], 11);
        checkOutput("nospk wr1", wrVal[1], 22);
        checkOutput("nospk wr2", wrVal[2], 33);
        checkOutput("nospk wr3", wrVal[3], 44);
        checkOutput("nospk wrCount", wrCount, 4);
        checkOutput("nospk in_clr", clrErr, 0);
        checkOutput("nospk excl", exclErr, 0);
        checkOutput("nospk spikes", hsCount, 0);
        checkOutput("nospk cycles", cyc, 13);
        checkOutput("nospk count", spike_count, 0);
        checkOutput("nospk busy", busy, 0);

        // Single spike with subtractive reset.
        applyStimulus(10, 20, 90, 40, 1, 2, 25, 4);
        runSweep(0, cyc);
        checkOutput("spk wr2", wrVal[2], 15);
        checkOutput("spk wr3", wrVal[3], 44);
        checkOutput("spk hs", hsCount, 1);
        checkOutput("spk id", hsId(0), 2);
        checkOutput("spk count", spike_count, 1);
        checkOutput("spk cycles", cyc, 14);

        // Two spikes, immediate ready, then five cycles of backpressure per event.
        applyStimulus(10, 90, 30, 95, 1, 20, 3, 10);
        runSweep(0, cyc);
        checkOutput("bp0 cycles", cyc, 15);
        checkOutput("bp0 wr1", wrVal[1], 10);
        checkOutput("bp0 wr3", wrVal[3], 5);
        readyWait = 5;
        applyStimulus(10, 90, 30, 95, 1, 20, 3, 10);
        runSweep(0, cyc);
        readyWait = 0;
        checkOutput("bp cycles", cyc, 25);
        checkOutput("bp hs", hsCount, 2);
        checkOutput("bp id0", hsId(0), 1);
        checkOutput("bp id1", hsId(1), 3);
        checkOutput("bp stable", stabErr, 0);
        checkOutput("bp count", spike_count, 2);

        // Signed wrap and exact-threshold spike.
        applyStimulus(32'h7FFF_FFF0, -50, 0, 0, 32, 150, 0, 0);
        runSweep(0, cyc);
        checkOutput("sgn wr0", wrVal[0], 32'h8000_0010);
        checkOutput("sgn wr1", wrVal[1], 0);
        checkOutput("sgn wr2", wrVal[2], 0);
        checkOutput("sgn hs", hsCount, 1);
        checkOutput("sgn id", hsId(0), 1);

        // Zero threshold: sum of zero fires and writes back zero.
        v_threshold = 32'd0;
        applyStimulus(0, 5, -3, 7, 0, -10, 3, 1);
        runSweep(0, cyc);
        checkOutput("zth wr0", wrVal[0], 0);
        checkOutput("zth wr1", wrVal[1], 32'hFFFF_FFFB);
        checkOutput("zth wr3", wrVal[3], 8);
        checkOutput("zth count", spike_count, 3);
        checkOutput("zth cycles", cyc, 16);
        v_threshold = 32'd100;

        // start while busy is neither obeyed nor queued.
        applyStimulus(10, 20, 30, 40, 1, 2, 3, 4);
        runSweep(5, cyc);
        repeat (20) @(negedge CLK);
        #1;
        checkOutput("busystart cycles", cyc, 13);
        checkOutput("busystart dones", doneCount, 1);
        checkOutput("busystart idle", busy, 0);
        checkOutput("count holds", spike_count, 0);

        // Reset mid-sweep aborts at once, then a fresh sweep starts from neuron 0.
        applyStimulus(10, 20, 30, 40, 1, 2, 3, 4);
        @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        #1;
        checkAllZero("midreset");
        checkOutput("midreset writes", wrCount, 1);
        RESET = 1'b0;
        applyStimulus(10, 20, 30, 40, 1, 2, 3, 4);
        runSweep(0, cyc);
        checkOutput("after reset cycles", cyc, 13);
        checkOutput("after reset writes", wrCount, 4);
        checkOutput("after reset wr0", wrVal[0], 11);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/neuron_update_scheduler.md
Name: neuron_update_scheduler

Overview:
- Per-timestep controller that sequences the LIF neuron datapath across all neurons of one core.
- For each neuron index it reads the stored membrane potential and accumulated synaptic input, forms the sum, and decides whether the neuron spiked.
- It applies the subtractive reset (V <- V - Vth) on spike and writes the result back.
- Each spike is emitted to the core's NoC packetiser over a valid/ready handshake.

Parameters:
- N_NEURONS, 16, neurons handled per timestep (>=1).
- ADDR_W, 4, neuron index width; must satisfy 2^ADDR_W >= N_NEURONS.
- DATA_W, 32, potential/input/threshold width (signed two's complement).

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  begin one timestep sweep; sampled only in IDLE.
- v_threshold  input  DATA_W  signed firing threshold; must be held stable while busy.
- busy  output  1  high from the cycle after start is accepted until DONE exits.
- done  output  1  one-cycle pulse at sweep completion.
- mem_addr  output  ADDR_W  neuron index for potential memory and input accumulator.
- mem_rd_en  output  1  read strobe; data returns the following cycle.
- mem_rd_data  input  DATA_W  stored potential, valid one cycle after mem_rd_en.
- in_rd_data  input  DATA_W  accumulated input for mem_addr; same timing as mem_rd_data.
- mem_wr_en  output  1  write strobe for potential memory.
- mem_wr_data  output  DATA_W  potential to write back.
- in_clr  output  1  clears the accumulator entry at mem_addr; asserted with mem_wr_en.
- spike_valid  output  1  spike event available.
- spike_ready  input  1  packetiser accepts the event.
- spike_id  output  ADDR_W  index of the spiking neuron.
- spike_count  output  ADDR_W+1  spikes emitted in the current or most recent sweep.

Behaviour:
- Reset: state=IDLE, index=0, and every output is 0 (busy, done, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, in_clr, spike_valid, spike_id, spike_count).
- A reset mid-sweep aborts immediately. No pending write or spike is completed.
- States: IDLE, READ, CAPTURE, WRITE, SPIKE, DONE.
- IDLE:
  - If start=1, clear index and spike_count, then go to READ.
  - start in any other state is ignored and is not queued.
- READ: mem_rd_en=1, mem_addr=index. Next state is CAPTURE.
- CAPTURE:
  - Register sum = mem_rd_data + in_rd_data. The addition is DATA_W bits with two's-complement wrap and no saturation.
  - spiked = (sum >= v_threshold), signed compare.
  - Next state is WRITE.
- WRITE:
  - mem_wr_en=1 and in_clr=1 for exactly one cycle. mem_addr=index.
  - mem_wr_data = spiked ? sum - v_threshold : sum, with wrap.
  - If spiked, go to SPIKE. Otherwise advance.
- SPIKE:
  - spike_valid=1 and spike_id=index, held stable until spike_ready=1 is sampled.
  - The handshake completes on that edge and spike_count increments. Then advance.
  - spike_ready while spike_valid=0 has no effect. A spike is never dropped or duplicated.
- Advance:
  - If index == N_NEURONS-1, go to DONE.
  - Otherwise increment index and go to READ.
  - The index never wraps past N_NEURONS-1.
- DONE: done=1 for one cycle, busy=0 in this cycle, then return to IDLE.
- Sweep latency:
  - Start accepted at edge k; READ of neuron 0 occupies cycle k+1.
  - Non-spiking neurons take 3 cycles each. Spiking neurons take 3 + (cycles waiting for ready) + 1.
  - With no spikes, done is high at cycle k+3N+1.
- Strobes are exclusive: mem_rd_en and mem_wr_en are never high in the same cycle.
- mem_addr holds its last value in IDLE.
- spike_count holds its value after DONE until the next accepted start.
- Zero threshold: sum=0 counts as a spike and writes back 0.

Optional Feature:
- Macro: NEURON_LEAK_EN.
- When defined:
  - Add input leak_shift [4:0].
  - In CAPTURE: sum = mem_rd_data - (mem_rd_data >>> leak_shift) + in_rd_data, using an arithmetic shift.
  - leak_shift=0 fully leaks the old potential; the sum is the input only.
  - Timing is unchanged.
- When undefined: no leak_shift port, and sum is exactly as above.

Test Plan:
- Reset and idle: RESET pulse mid-sweep with N=4 -> next cycle all outputs 0, state IDLE, no mem_wr_en. A later start runs a full sweep from index 0.
- No spikes: N=4, Vth=100, potentials {10,20,30,40}, inputs {1,2,3,4} -> writes {11,22,33,44}, in_clr on each write, no spike_valid, done exactly 13 cycles after start accepted, spike_count=0.
- Spike with reset: N=4, Vth=100, neuron 2 potential 90, input 25 -> writes 15 to address 2, spike_id=2, spike_count=1.
- Backpressure: two spiking neurons (1 and 3), spike_ready held low 5 cycles per event -> spike_valid and spike_id stable throughout, exactly 2 handshakes, spike_count=2, done delayed by 10 cycles.
- Signed boundaries:
  - Potential 32'h7FFFFFF0 + input 32 wraps negative -> no spike.
  - Potential -50 + input 150 with Vth=100 -> spike, write-back 0.
  - start pulsed while busy -> ignored, single done.
- NEURON_LEAK_EN: leak_shift=1, potential 80, input 10, Vth=100 -> sum 50, write-back 50, no spike. leak_shift=0 -> sum 10.
